// File: rtl/rom_arbiter.sv
// Two-port (IF/LS) arbiter in front of a combinational-read ROM with registered per-port responses.
// Optional grant/conflict statistics counters are enabled with `define ROM_ARB_STATS_EN.
module rom_arbiter #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 1024,
  parameter int MAX_WAIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_req,
  input  logic [WIDTH-1:0] if_addr,
  output logic             if_gnt,
  output logic             if_rvalid,
  input  logic             if_rready,
  output logic [WIDTH-1:0] if_rdata,
  output logic             if_rerr,
  input  logic             ls_req,
  input  logic [WIDTH-1:0] ls_addr,
  output logic             ls_gnt,
  output logic             ls_rvalid,
  input  logic             ls_rready,
  output logic [WIDTH-1:0] ls_rdata,
  output logic             ls_rerr,
  output logic             rom_ce,
  output logic [WIDTH-1:0] rom_addr,
  input  logic [WIDTH-1:0] rom_data
`ifdef ROM_ARB_STATS_EN
  ,
  output logic [31:0]      stat_if_cnt,
  output logic [31:0]      stat_ls_cnt,
  output logic [31:0]      stat_conf_cnt
`endif
);

  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  // Port index 0 is IF, index 1 is LS.
  logic [1:0]       req;
  logic [1:0]       rready;
  logic [1:0]       rvalid;
  logic [1:0]       rerr;
  logic [1:0]       elig;
  logic [1:0]       gnt;
  logic [1:0]       err;
  logic [WIDTH-1:0] addr  [2];
  logic [WIDTH-1:0] rdata [2];
  logic [3:0]       starve_cnt_reg;
  logic [WIDTH-1:0] sel_addr;
  logic             sel_err;

  assign req     = {ls_req, if_req};
  assign rready  = {ls_rready, if_rready};
  assign addr[0] = if_addr;
  assign addr[1] = ls_addr;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      logic             rvalid_reg;
      logic             rerr_reg;
      logic [WIDTH-1:0] rdata_reg;

      // A port still holding an unconsumed response cannot take a new word.
      assign elig[gi] = req[gi] & (~rvalid_reg | rready[gi]);
      assign err[gi]  = (addr[gi][1:0] != 2'b00) |
                        (addr[gi][WIDTH-1:ADDR_WIDTH+2] != '0);

      always_ff @(posedge clk) begin
        if (rst) begin
          rvalid_reg <= 1'b0;
          rerr_reg   <= 1'b0;
          rdata_reg  <= '0;
        end else if (gnt[gi]) begin
          rvalid_reg <= 1'b1;
          rerr_reg   <= err[gi];
          rdata_reg  <= err[gi] ? '0 : rom_data;
        end else if (rready[gi]) begin
          rvalid_reg <= 1'b0;
          rerr_reg   <= 1'b0;
        end
      end

      assign rvalid[gi] = rvalid_reg;
      assign rerr[gi]   = rerr_reg;
      assign rdata[gi]  = rdata_reg;
    end
  endgenerate

  // LS wins conflicts until IF has been denied MAX_WAIT times in a row.
  always_comb begin
    gnt = 2'b00;
    if (!rst) begin
      if (elig[0] && elig[1]) begin
        gnt = (starve_cnt_reg >= MAX_WAIT_C) ? 2'b01 : 2'b10;
      end else begin
        gnt = elig;
      end
    end
  end

  assign sel_addr = gnt[0] ? addr[0] : addr[1];
  assign sel_err  = gnt[0] ? err[0]  : err[1];
  assign rom_ce   = (|gnt) & ~sel_err;
  assign rom_addr = rom_ce ? sel_addr : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_reg <= 4'd0;
    end else if (gnt[0] || !if_req) begin
      starve_cnt_reg <= 4'd0;
    end else if (elig[0] && starve_cnt_reg != 4'd15) begin
      starve_cnt_reg <= starve_cnt_reg + 4'd1;
    end
  end

  assign if_gnt    = gnt[0];
  assign ls_gnt    = gnt[1];
  assign if_rvalid = rvalid[0];
  assign ls_rvalid = rvalid[1];
  assign if_rerr   = rerr[0];
  assign ls_rerr   = rerr[1];
  assign if_rdata  = rdata[0];
  assign ls_rdata  = rdata[1];

`ifdef ROM_ARB_STATS_EN
  logic [31:0] stat_if_reg;
  logic [31:0] stat_ls_reg;
  logic [31:0] stat_conf_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_if_reg   <= '0;
      stat_ls_reg   <= '0;
      stat_conf_reg <= '0;
    end else begin
      if (gnt[0])           stat_if_reg   <= stat_if_reg + 32'd1;
      if (gnt[1])           stat_ls_reg   <= stat_ls_reg + 32'd1;
      if (elig[0] && elig[1]) stat_conf_reg <= stat_conf_reg + 32'd1;
    end
  end

  assign stat_if_cnt   = stat_if_reg;
  assign stat_ls_cnt   = stat_ls_reg;
  assign stat_conf_cnt = stat_conf_reg;
`endif

endmodule

// File: tb/tb_rom_arbiter.sv
// Scoreboard bench for rom_arbiter: directed steps check grants/ROM drive and queue expected
// responses; a negedge monitor pops and compares each accepted response.
module tb_rom_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, ls_req, if_rready, ls_rready;
  logic [31:0] if_addr, ls_addr;
  logic        if_gnt, ls_gnt, if_rvalid, ls_rvalid, if_rerr, ls_rerr, rom_ce;
  logic [31:0] if_rdata, ls_rdata, rom_addr, rom_data;
  logic [31:0] mem [1024];
  logic [32:0] q_if [$];
  logic [32:0] q_ls [$];
  int          checks = 0;
  int          passes = 0;

  always #5 clk = ~clk;

  rom_arbiter #(.WIDTH(32), .DEPTH(1024), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rready(if_rready), .if_rdata(if_rdata), .if_rerr(if_rerr),
    .ls_req(ls_req), .ls_addr(ls_addr), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid),
    .ls_rready(ls_rready), .ls_rdata(ls_rdata), .ls_rerr(ls_rerr),
    .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_data(rom_data)
  );

  assign rom_data = mem[rom_addr[11:2]];

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEADBEEF : (32'hC0DE0000 | {22'd0, a[11:2]});
  endfunction

  function automatic logic [32:0] exp_resp(input logic [31:0] a);
    logic bad;
    bad = (a[1:0] != 2'b00) || (a[31:12] != 20'd0);
    return bad ? {1'b1, 32'h0} : {1'b0, rom_word(a)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Drive one cycle of inputs, check combinational grant/ROM outputs, queue expected responses.
  task automatic step(input logic r, input logic ir, input logic [31:0] ia,
                      input logic lr, input logic [31:0] la, input logic irr, input logic lrr,
                      input logic eig, input logic elg, input logic ece, input logic [31:0] era,
                      input string tag);
    rst = r; if_req = ir; if_addr = ia; ls_req = lr; ls_addr = la;
    if_rready = irr; ls_rready = lrr;
    @(negedge clk);
    chk({tag, "_if_gnt"}, 32'(if_gnt), 32'(eig));
    chk({tag, "_ls_gnt"}, 32'(ls_gnt), 32'(elg));
    chk({tag, "_rom_ce"}, 32'(rom_ce), 32'(ece));
    chk({tag, "_rom_addr"}, rom_addr, era);
    if (eig) q_if.push_back(exp_resp(ia));
    if (elg) q_ls.push_back(exp_resp(la));
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, tag);
  endtask

  // Monitor: every accepted response is matched against the head of its port's queue.
  always @(negedge clk) begin
    logic [32:0] e;
    if (rst === 1'b0) begin
      if (if_rvalid && if_rready) begin
        if (q_if.size() == 0) begin
          checks++;
          $display("FAIL if_resp_unexpected: got data %h err %b expected none", if_rdata, if_rerr);
        end else begin
          e = q_if.pop_front();
          chk("if_rdata", if_rdata, e[31:0]);
          chk("if_rerr", 32'(if_rerr), 32'(e[32]));
        end
      end
      if (ls_rvalid && ls_rready) begin
        if (q_ls.size() == 0) begin
          checks++;
          $display("FAIL ls_resp_unexpected: got data %h err %b expected none", ls_rdata, ls_rerr);
        end else begin
          e = q_ls.pop_front();
          chk("ls_rdata", ls_rdata, e[31:0]);
          chk("ls_rerr", 32'(ls_rerr), 32'(e[32]));
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = rom_word(32'(i) << 2);

    // Reset with both ports requesting: nothing granted, responses cleared.
    step(1'b1, 1'b1, 32'h10, 1'b1, 32'h20, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, "rst0");
    chk("rst_if_rvalid", 32'(if_rvalid), 32'd0);
    chk("rst_ls_rvalid", 32'(ls_rvalid), 32'd0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_ls_rerr", 32'(ls_rerr), 32'd0);
    step(1'b1, 1'b1, 32'h10, 1'b1, 32'h20, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, "rst1");

    // Continuous conflict: LS x4 then IF x1, repeating.
    for (int k = 0; k < 10; k++) begin
      logic       wi;
      logic [31:0] ia, la;
      wi = (k % 5 == 4);
      ia = 32'h100 + 32'(k) * 4;
      la = 32'h200 + 32'(k) * 4;
      step(1'b0, 1'b1, ia, 1'b1, la, 1'b1, 1'b1, wi, ~wi, 1'b1, wi ? ia : la, "conf");
    end
    idle("idle0");

    // Single port read of word 4.
    step(1'b0, 1'b1, 32'h10, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h10, "single");
    idle("idle1");

    // Backpressure on LS: IF gets every cycle, LS data held.
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h30, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h30, "bp0");
    for (int j = 0; j < 3; j++) begin
      step(1'b0, 1'b1, 32'h50 + 32'(j) * 4, 1'b1, 32'h34, 1'b1, 1'b0,
           1'b1, 1'b0, 1'b1, 32'h50 + 32'(j) * 4, "bp_hold");
      chk("bp_ls_rvalid", 32'(ls_rvalid), 32'd1);
      chk("bp_ls_rdata", ls_rdata, rom_word(32'h30));
    end
    step(1'b0, 1'b1, 32'h5C, 1'b1, 32'h34, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h34, "bp_rel");
    idle("idle2");

    // Range / alignment errors and the last valid word.
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, "err_mis");
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h1000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, "err_rng");
    step(1'b0, 1'b1, 32'h1003, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, "err_if");
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'hFFC, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'hFFC, "last");
    idle("idle3");

    // Reset while both responses are pending.
    step(1'b0, 1'b1, 32'h60, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h60, "mr_if");
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h64, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h64, "mr_ls");
    chk("mr_if_rvalid_pre", 32'(if_rvalid), 32'd1);
    chk("mr_ls_rvalid_pre", 32'(ls_rvalid), 32'd1);
    step(1'b1, 1'b1, 32'h68, 1'b1, 32'h6C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, "mr_rst");
    chk("mr_if_rvalid", 32'(if_rvalid), 32'd0);
    chk("mr_ls_rvalid", 32'(ls_rvalid), 32'd0);
    chk("mr_ls_rdata", ls_rdata, 32'h0);
    q_if.delete();
    q_ls.delete();

    // Starvation count must restart from zero after reset.
    for (int k = 0; k < 3; k++)
      step(1'b0, 1'b1, 32'h70, 1'b1, 32'h74, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h74, "sr_pre");
    step(1'b1, 1'b1, 32'h70, 1'b1, 32'h74, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, "sr_rst");
    q_if.delete();
    q_ls.delete();
    for (int k = 0; k < 5; k++) begin
      logic wi;
      wi = (k == 4);
      step(1'b0, 1'b1, 32'h80, 1'b1, 32'h84, 1'b1, 1'b1, wi, ~wi, 1'b1,
           wi ? 32'h80 : 32'h84, "sr_post");
    end

    idle("drain0");
    idle("drain1");
    chk("q_if_empty", 32'(q_if.size()), 32'd0);
    chk("q_ls_empty", 32'(q_ls.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
